// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data RAM (word/half access), syscall halt and debug read port.
// Optional DMEM_STAT_EN adds saturating load/store counters (load_cnt, store_cnt).
module ex_mem_stage #(
  parameter int ADDR_W = 10,
  parameter int PC_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              clear,
  input  logic [PC_W-1:0]   pc_4_ex,
  input  logic [31:0]       alu_res_ex,
  input  logic [31:0]       b_ex,
  input  logic [4:0]        rw_ex,
  input  logic              we_ex,
  input  logic [1:0]        wsel_ex,
  input  logic              ram_sto_ex,
  input  logic              ram_load_ex,
  input  logic              half_ex,
  input  logic              syscall_ex,
  input  logic [31:0]       v0_ex,
  input  logic [5:0]        ram_addr,
  output logic [PC_W-1:0]   pc_4_mem,
  output logic [31:0]       alu_res_mem,
  output logic [4:0]        rw_mem,
  output logic              we_mem,
  output logic [1:0]        wsel_mem,
  output logic [31:0]       mem_data,
  output logic [31:0]       wb_data,
  output logic [31:0]       debug_word,
  output logic              misaligned,
  output logic              halted
`ifdef DMEM_STAT_EN
  ,
  output logic [15:0]       load_cnt,
  output logic [15:0]       store_cnt
`endif
);

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       b_mem;
  logic [31:0]       v0_mem;
  logic              we_r;
  logic              sto_mem;
  logic              load_mem;
  logic              half_mem;
  logic              syscall_mem;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] dbg_idx;
  logic [31:0]       rd_word;

  // EX/MEM register; once halted everything freezes until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_4_mem    <= '0;
      alu_res_mem <= '0;
      b_mem       <= '0;
      rw_mem      <= '0;
      we_r        <= 1'b0;
      wsel_mem    <= '0;
      sto_mem     <= 1'b0;
      load_mem    <= 1'b0;
      half_mem    <= 1'b0;
      syscall_mem <= 1'b0;
      v0_mem      <= '0;
      halted      <= 1'b0;
    end else if (!halted) begin
      if (syscall_mem && v0_mem == 32'd10) halted <= 1'b1;
      if (clear) begin
        pc_4_mem    <= '0;
        alu_res_mem <= '0;
        b_mem       <= '0;
        rw_mem      <= '0;
        we_r        <= 1'b0;
        wsel_mem    <= '0;
        sto_mem     <= 1'b0;
        load_mem    <= 1'b0;
        half_mem    <= 1'b0;
        syscall_mem <= 1'b0;
        v0_mem      <= '0;
      end else if (go) begin
        pc_4_mem    <= pc_4_ex;
        alu_res_mem <= alu_res_ex;
        b_mem       <= b_ex;
        rw_mem      <= rw_ex;
        we_r        <= we_ex;
        wsel_mem    <= wsel_ex;
        sto_mem     <= ram_sto_ex;
        load_mem    <= ram_load_ex;
        half_mem    <= half_ex;
        syscall_mem <= syscall_ex;
        v0_mem      <= v0_ex;
      end
    end
  end

  assign we_mem     = we_r & ~halted;
  assign idx        = alu_res_mem[ADDR_W+1:2];
  assign dbg_idx    = ADDR_W'(ram_addr);
  assign rd_word    = mem[idx];
  assign debug_word = mem[dbg_idx];
  assign misaligned = (sto_mem | load_mem) &
                      (half_mem ? alu_res_mem[0] : |alu_res_mem[1:0]);

  // Half stores take the low half of the store data and leave the other half intact
  always_ff @(posedge clk) begin
    if (sto_mem && !misaligned && !halted) begin
      if (!half_mem)            mem[idx]        <= b_mem;
      else if (alu_res_mem[1])  mem[idx][31:16] <= b_mem[15:0];
      else                      mem[idx][15:0]  <= b_mem[15:0];
    end
  end

  always_comb begin
    mem_data = rd_word;
    if (misaligned)    mem_data = '0;
    else if (half_mem) mem_data = {16'h0, alu_res_mem[1] ? rd_word[31:16] : rd_word[15:0]};
  end

  always_comb begin
    case (wsel_mem)
      2'b01:   wb_data = mem_data;
      2'b10:   wb_data = {{(32-PC_W){1'b0}}, pc_4_mem};
      default: wb_data = alu_res_mem;
    endcase
  end

`ifdef DMEM_STAT_EN
  // Count only when the access actually leaves MEM, so stalls are not double-counted
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else if (!halted && (go || clear)) begin
      if (load_mem && !misaligned && load_cnt != 16'hFFFF)  load_cnt  <= load_cnt + 16'd1;
      if (sto_mem && !misaligned && store_cnt != 16'hFFFF)  store_cnt <= store_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expectations queued at issue, checked when the instr is in MEM.
module tb_ex_mem_stage;
  localparam int ADDR_W = 10;
  localparam int PC_W   = 12;

  logic              clk = 1'b0;
  logic              rst, go, clear;
  logic [PC_W-1:0]   pc_4_ex;
  logic [31:0]       alu_res_ex, b_ex, v0_ex;
  logic [4:0]        rw_ex;
  logic              we_ex, ram_sto_ex, ram_load_ex, half_ex, syscall_ex;
  logic [1:0]        wsel_ex;
  logic [5:0]        ram_addr;
  logic [PC_W-1:0]   pc_4_mem;
  logic [31:0]       alu_res_mem, mem_data, wb_data, debug_word;
  logic [4:0]        rw_mem;
  logic              we_mem, misaligned, halted;
  logic [1:0]        wsel_mem;
`ifdef DMEM_STAT_EN
  logic [15:0]       load_cnt, store_cnt;
`endif

  ex_mem_stage #(.ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .go(go), .clear(clear),
    .pc_4_ex(pc_4_ex), .alu_res_ex(alu_res_ex), .b_ex(b_ex), .rw_ex(rw_ex),
    .we_ex(we_ex), .wsel_ex(wsel_ex), .ram_sto_ex(ram_sto_ex), .ram_load_ex(ram_load_ex),
    .half_ex(half_ex), .syscall_ex(syscall_ex), .v0_ex(v0_ex), .ram_addr(ram_addr),
    .pc_4_mem(pc_4_mem), .alu_res_mem(alu_res_mem), .rw_mem(rw_mem), .we_mem(we_mem),
    .wsel_mem(wsel_mem), .mem_data(mem_data), .wb_data(wb_data), .debug_word(debug_word),
    .misaligned(misaligned), .halted(halted)
`ifdef DMEM_STAT_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] md;
    logic [31:0] wb;
    logic        mis;
    logic        we;
  } exp_t;

  exp_t            sb[$];
  logic [31:0]     ref_mem [2**ADDR_W];
  logic [PC_W-1:0] pc_ctr = '0;
  int              total = 0;
  int              bad   = 0;

  task automatic bubble();
    pc_4_ex = '0; alu_res_ex = '0; b_ex = '0; rw_ex = '0; we_ex = 1'b0; wsel_ex = '0;
    ram_sto_ex = 1'b0; ram_load_ex = 1'b0; half_ex = 1'b0; syscall_ex = 1'b0; v0_ex = '0;
  endtask

  // Drive one instruction, predict its MEM-stage outputs from the reference memory, check one cycle later
  task automatic issue(input logic [31:0] alu, input logic [31:0] b, input logic [1:0] wsel,
                       input logic sto, input logic ld, input logic half);
    exp_t        e, got;
    logic [31:0] word;
    logic [9:0]  i;
    pc_ctr = pc_ctr + 12'd4;
    i    = alu[11:2];
    word = ref_mem[i];
    e.mis = (sto | ld) & (half ? alu[0] : |alu[1:0]);
    if (e.mis)     e.md = 32'h0;
    else if (half) e.md = alu[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
    else           e.md = word;
    case (wsel)
      2'b01:   e.wb = e.md;
      2'b10:   e.wb = {20'h0, pc_ctr};
      default: e.wb = alu;
    endcase
    e.we = ~sto;
    if (sto && !e.mis) begin
      if (!half)        ref_mem[i] = b;
      else if (alu[1])  ref_mem[i][31:16] = b[15:0];
      else              ref_mem[i][15:0]  = b[15:0];
    end
    bubble();
    pc_4_ex = pc_ctr; alu_res_ex = alu; b_ex = b; rw_ex = 5'd3; we_ex = ~sto; wsel_ex = wsel;
    ram_sto_ex = sto; ram_load_ex = ld; half_ex = half;
    go = 1'b1; clear = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    total += 4;
    if (mem_data !== got.md) begin
      bad++; $display("FAIL mem_data a=%h got=%h want=%h", alu, mem_data, got.md);
    end
    if (wb_data !== got.wb) begin
      bad++; $display("FAIL wb_data a=%h got=%h want=%h", alu, wb_data, got.wb);
    end
    if (misaligned !== got.mis) begin
      bad++; $display("FAIL misaligned a=%h got=%b want=%b", alu, misaligned, got.mis);
    end
    if (we_mem !== got.we) begin
      bad++; $display("FAIL we_mem a=%h got=%b want=%b", alu, we_mem, got.we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; clear = 1'b0; ram_addr = '0; bubble();
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (alu_res_mem !== 32'h0 || pc_4_mem !== '0 || rw_mem !== '0) begin
      bad++; $display("FAIL reset_regs got alu=%h pc=%h rw=%h want 0", alu_res_mem, pc_4_mem, rw_mem);
    end
    if (we_mem !== 1'b0 || wsel_mem !== 2'b00) begin
      bad++; $display("FAIL reset_ctl got we=%b wsel=%b want 0", we_mem, wsel_mem);
    end
    if (wb_data !== 32'h0) begin
      bad++; $display("FAIL reset_wb got=%h want=0", wb_data);
    end
    if (halted !== 1'b0) begin
      bad++; $display("FAIL reset_halted got=%b want=0", halted);
    end
    if (misaligned !== 1'b0) begin
      bad++; $display("FAIL reset_misaligned got=%b want=0", misaligned);
    end
`ifdef DMEM_STAT_EN
    if (load_cnt !== 16'h0 || store_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_cnt got l=%0d s=%0d want 0", load_cnt, store_cnt);
    end
`else
    if (rw_mem !== 5'd0) begin
      bad++; $display("FAIL reset_rw got=%h want=0", rw_mem);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stall();
    bubble();
    ram_sto_ex = 1'b1; alu_res_ex = 32'h40; b_ex = 32'hA5A5A5A5; go = 1'b1;
    ref_mem[16] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    go = 1'b0; alu_res_ex = 32'h44; b_ex = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    total += 2;
    if (alu_res_mem !== 32'h40) begin
      bad++; $display("FAIL stall_hold got=%h want=40", alu_res_mem);
    end
`ifdef DMEM_STAT_EN
    if (store_cnt !== 16'd0) begin
      bad++; $display("FAIL stall_cnt_held got=%0d want=0", store_cnt);
    end
`else
    if (misaligned !== 1'b0) begin
      bad++; $display("FAIL stall_mis got=%b want=0", misaligned);
    end
`endif
    bubble(); go = 1'b1; ram_addr = 6'd16;
    @(posedge clk); #1;
    total += 2;
    if (debug_word !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL stall_store got=%h want=a5a5a5a5", debug_word);
    end
`ifdef DMEM_STAT_EN
    if (store_cnt !== 16'd1 || load_cnt !== 16'd0) begin
      bad++; $display("FAIL stall_cnt got s=%0d l=%0d want s=1 l=0", store_cnt, load_cnt);
    end
`else
    if (we_mem !== 1'b0) begin
      bad++; $display("FAIL stall_bubble_we got=%b want=0", we_mem);
    end
`endif
  endtask

  task automatic test_word();
    issue(32'h10, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0, 1'b0);
    issue(32'h10, 32'h0,        2'b01, 1'b0, 1'b1, 1'b0);
    issue(32'h10, 32'h0,        2'b10, 1'b0, 1'b1, 1'b0);
    ram_addr = 6'd4; #1;
    total++;
    if (debug_word !== 32'hDEADBEEF) begin
      bad++; $display("FAIL word_debug got=%h want=deadbeef", debug_word);
    end
  endtask

  task automatic test_half();
    issue(32'h12, 32'h00001234, 2'b00, 1'b1, 1'b0, 1'b1);
    issue(32'h10, 32'h0,        2'b01, 1'b0, 1'b1, 1'b0);
    issue(32'h12, 32'h0,        2'b01, 1'b0, 1'b1, 1'b1);
    issue(32'h10, 32'h0,        2'b01, 1'b0, 1'b1, 1'b1);
    issue(32'h10, 32'hFFFF5678, 2'b00, 1'b1, 1'b0, 1'b1);
    issue(32'h10, 32'h0,        2'b01, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_misaligned_wrap();
    issue(32'h11,   32'hFFFFFFFF, 2'b00, 1'b1, 1'b0, 1'b0);
    issue(32'h13,   32'h0,        2'b01, 1'b0, 1'b1, 1'b0);
    issue(32'h11,   32'h0,        2'b01, 1'b0, 1'b1, 1'b1);
    issue(32'h10,   32'h0,        2'b01, 1'b0, 1'b1, 1'b0);
    issue(32'h1010, 32'h0BADF00D, 2'b00, 1'b1, 1'b0, 1'b0);
    issue(32'h10,   32'h0,        2'b01, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    bubble();
    ram_sto_ex = 1'b1; we_ex = 1'b1; alu_res_ex = 32'h30; b_ex = 32'h77; clear = 1'b1; go = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total += 2;
    if (alu_res_mem !== 32'h0 || misaligned !== 1'b0) begin
      bad++; $display("FAIL clear_regs got alu=%h mis=%b want 0", alu_res_mem, misaligned);
    end
    if (we_mem !== 1'b0) begin
      bad++; $display("FAIL clear_we got=%b want=0", we_mem);
    end
  endtask

  task automatic test_halt();
    issue(32'h20, 32'h11111111, 2'b00, 1'b1, 1'b0, 1'b0);
    bubble(); syscall_ex = 1'b1; v0_ex = 32'd1; we_ex = 1'b1; go = 1'b1;
    @(posedge clk); #1;
    bubble();
    @(posedge clk); #1;
    total++;
    if (halted !== 1'b0) begin
      bad++; $display("FAIL halt_v0_1 got=%b want=0", halted);
    end
    syscall_ex = 1'b1; v0_ex = 32'd10; we_ex = 1'b1; alu_res_ex = 32'h55;
    @(posedge clk); #1;
    total++;
    if (halted !== 1'b0) begin
      bad++; $display("FAIL halt_early got=%b want=0", halted);
    end
    bubble(); ram_sto_ex = 1'b1; we_ex = 1'b1; alu_res_ex = 32'h20; b_ex = 32'hCAFEF00D;
    @(posedge clk); #1;
    total += 3;
    if (halted !== 1'b1) begin
      bad++; $display("FAIL halt_set got=%b want=1", halted);
    end
    if (alu_res_mem !== 32'h20) begin
      bad++; $display("FAIL halt_last_capture got=%h want=20", alu_res_mem);
    end
    if (we_mem !== 1'b0) begin
      bad++; $display("FAIL halt_we got=%b want=0", we_mem);
    end
    alu_res_ex = 32'h99; clear = 1'b1; ram_addr = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;
    total += 3;
    if (alu_res_mem !== 32'h20) begin
      bad++; $display("FAIL halt_frozen got=%h want=20", alu_res_mem);
    end
    if (debug_word !== 32'h11111111) begin
      bad++; $display("FAIL halt_store_blocked got=%h want=11111111", debug_word);
    end
    if (halted !== 1'b1) begin
      bad++; $display("FAIL halt_sticky got=%b want=1", halted);
    end
    bubble(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total += 2;
    if (halted !== 1'b0) begin
      bad++; $display("FAIL halt_rst got=%b want=0", halted);
    end
    if (alu_res_mem !== 32'h0) begin
      bad++; $display("FAIL halt_rst_regs got=%h want=0", alu_res_mem);
    end
  endtask

  initial begin
    for (int k = 0; k < 2**ADDR_W; k++) ref_mem[k] = 32'h0;
    test_reset();
    test_stall();
    test_word();
    test_half();
    test_misaligned_wrap();
    test_clear();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
